// File: rtl/remote_command_encoder.sv
// remote_command_encoder
//   Turns five front-panel push-buttons into a paced one-cycle command
//   stream. Shadow copies of eco, AC mode, person count and security are
//   kept so each command carries an absolute value. Commands are queued in
//   a small FIFO and sent with at least GAP_CYCLES idle cycles after each
//   valid pulse.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   btn_*_i                 pre-synchronised button levels
//   command_valid_o         one-cycle command strobe
//   command_type_o          0 eco, 1 AC mode, 2 person count, 3 security
//   command_data_o          absolute setting value, zero-extended
//   fifo_full_o             FIFO holds FIFO_DEPTH entries
//   busy_o                  FIFO non-empty or transmitter not idle
module remote_command_encoder #(
   parameter int TYPE_W     = 2,
   parameter int DATA_W     = 8,
   parameter int PERSON_MAX = 15,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              btn_eco_i,
   input  logic              btn_ac_mode_i,
   input  logic              btn_person_inc_i,
   input  logic              btn_person_dec_i,
   input  logic              btn_security_i,
   output logic              command_valid_o,
   output logic [TYPE_W-1:0] command_type_o,
   output logic [DATA_W-1:0] command_data_o,
   output logic              fifo_full_o,
   output logic              busy_o
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [DATA_W-1:0] PMAX     = DATA_W'(PERSON_MAX);

   // Bit position doubles as service priority: lowest index wins.
   localparam int ECO = 0;
   localparam int AC  = 1;
   localparam int INC = 2;
   localparam int DEC = 3;
   localparam int SEC = 4;

   typedef struct packed {
      logic [TYPE_W-1:0] ctype;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   logic [4:0]        btn, btn_q, press, pend, grant;
   logic              eco, eco_n, sec, sec_n;
   logic [1:0]        ac, ac_n;
   logic [DATA_W-1:0] persons, persons_n;
   logic              wr_en, rd_en, empty, full;
   entry_t            wr_entry;
   entry_t            mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   state_t            state;
   logic [CNT_W-1:0]  cnt;

   assign btn   = {btn_security_i, btn_person_dec_i, btn_person_inc_i,
                   btn_ac_mode_i, btn_eco_i};
   assign press = btn & ~btn_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = (state == ST_IDLE) && !empty;

   // Isolate the lowest set pending bit; nothing is granted while full so
   // flags simply wait.
   assign grant = full ? 5'd0 : (pend & (~pend + 5'd1));

   always_comb begin
      wr_en     = 1'b0;
      wr_entry  = '0;
      eco_n     = eco;
      ac_n      = ac;
      persons_n = persons;
      sec_n     = sec;
      if (grant[ECO]) begin
         eco_n          = ~eco;
         wr_en          = 1'b1;
         wr_entry.ctype = TYPE_W'(0);
         wr_entry.data  = DATA_W'(eco_n);
      end else if (grant[AC]) begin
         ac_n           = (ac == 2'd2) ? 2'd0 : ac + 2'd1;
         wr_en          = 1'b1;
         wr_entry.ctype = TYPE_W'(1);
         wr_entry.data  = DATA_W'(ac_n);
      end else if (grant[INC]) begin
         // A saturated step consumes the flag but sends nothing.
         if (persons != PMAX) begin
            persons_n      = persons + 1'b1;
            wr_en          = 1'b1;
            wr_entry.ctype = TYPE_W'(2);
            wr_entry.data  = persons_n;
         end
      end else if (grant[DEC]) begin
         if (persons != '0) begin
            persons_n      = persons - 1'b1;
            wr_en          = 1'b1;
            wr_entry.ctype = TYPE_W'(2);
            wr_entry.data  = persons_n;
         end
      end else if (grant[SEC]) begin
         sec_n          = ~sec;
         wr_en          = 1'b1;
         wr_entry.ctype = TYPE_W'(3);
         wr_entry.data  = DATA_W'(sec_n);
      end
   end

   // Edge detect, pending flags, shadows and FIFO pointers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // Loading the live level hides a button held through reset.
         btn_q   <= btn;
         pend    <= '0;
         eco     <= 1'b0;
         ac      <= 2'd0;
         persons <= '0;
         sec     <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         btn_q   <= btn;
         // A press landing on the cycle its flag is serviced re-arms it.
         pend    <= (pend & ~grant) | press;
         eco     <= eco_n;
         ac      <= ac_n;
         persons <= persons_n;
         sec     <= sec_n;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
   end

   // Transmit FSM with registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         command_valid_o <= 1'b0;
         command_type_o  <= '0;
         command_data_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  command_type_o  <= mem[rd_ptr[AW-1:0]].ctype;
                  command_data_o  <= mem[rd_ptr[AW-1:0]].data;
                  command_valid_o <= 1'b1;
                  state           <= ST_SEND;
               end
            end
            ST_SEND: begin
               command_valid_o <= 1'b0;
               cnt             <= '0;
               state           <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) state <= ST_IDLE;
               else                 cnt   <= cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign fifo_full_o = full;
   assign busy_o      = !empty || (state != ST_IDLE);

endmodule
